// File: rtl/pes_rca_acc.sv
// Burst accumulator for 5-bit ripple-carry adder results ({cout, sum}).
// Sums 1..16 samples per burst, flags wrap-around, and hands the total over a valid/ready port.
module pes_rca_acc #(
    parameter int unsigned ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [3:0]       burst_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_sum,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int unsigned LEN_W = 4;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] w_len_nxt;

    logic [ACC_W-1:0] w_sample;
    logic [ACC_W:0]   w_sum;
    logic             w_accept;

    assign w_sample = ACC_W'({in_cout, in_sum});
    assign w_sum    = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_sample);
    assign w_accept = in_valid && in_ready;

    // Outputs are decoded from registers only; no input reaches an output combinationally.
    assign in_ready  = (r_state != S_DONE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_data  = r_acc;
    assign out_ovf   = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_ovf   <= w_ovf_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
        end
    end

    // Next-state and datapath update; clear overrides acceptance and the output handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_ovf_nxt   = r_ovf;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_acc_nxt   = w_sample;
                    w_len_nxt   = burst_len;
                    w_cnt_nxt   = CNT_W'(1);
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = (burst_len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_accept) begin
                    w_acc_nxt = w_sum[ACC_W-1:0];
                    w_ovf_nxt = r_ovf | w_sum[ACC_W];
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    // This sample brings the count to length+1, closing the burst.
                    if (r_cnt == CNT_W'(r_len)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (clear) begin
            w_state_nxt = S_IDLE;
            w_acc_nxt   = '0;
            w_ovf_nxt   = 1'b0;
            w_cnt_nxt   = '0;
        end
    end

endmodule

// File: tb/tb_pes_rca_acc.sv
// Scoreboarded random/directed bench for pes_rca_acc; the reference is the plain
// sum of each burst's samples, reduced modulo 2^ACC_W with wrap flagged when it overflows.
module tb_pes_rca_acc;

    localparam int unsigned ACC_W = 8;
    localparam int          MODV  = 1 << ACC_W;

    typedef struct {
        int data;
        int ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic [3:0]       burst_len;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_sum;
    logic             in_cout;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;
    logic             busy;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    int   q[$];

    pes_rca_acc #(.ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .burst_len (burst_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_cout   (in_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result monitor: compares every completed output handshake against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && !clear && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got data %0d with empty scoreboard", out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_data", int'(out_data), e.data);
                check("sb_ovf", int'(out_ovf), e.ovf);
            end
        end
    end

    // Drives one burst; abort_after>0 pulses clear after that many samples.
    // bp<0 picks a random number of backpressure cycles.
    task automatic run_burst(input int vals[$], input int max_gap, input int abort_after, input int bp);
        int   n;
        int   total;
        int   k;
        exp_t e;
        n     = vals.size();
        total = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && max_gap > 0) begin
                k = int'($urandom_range(max_gap, 0));
                repeat (k) begin
                    in_valid  = 1'b0;
                    burst_len = 4'($urandom);
                    tick();
                    check("gap_no_valid", int'(out_valid), 0);
                end
            end
            if (i == 0) burst_len = 4'(n - 1);
            {in_cout, in_sum} = 5'(vals[i]);
            in_valid = 1'b1;
            check("in_ready_accum", int'(in_ready), 1);
            tick();
            in_valid  = 1'b0;
            burst_len = 4'($urandom);
            total += vals[i];
            if (abort_after == i + 1) begin
                clear = 1'b1;
                tick();
                clear = 1'b0;
                check("clr_busy", int'(busy), 0);
                check("clr_out_valid", int'(out_valid), 0);
                check("clr_out_data", int'(out_data), 0);
                check("clr_out_ovf", int'(out_ovf), 0);
                return;
            end
        end
        e.data = total % MODV;
        e.ovf  = (total >= MODV) ? 1 : 0;
        sb.push_back(e);
        check("out_valid_latency", int'(out_valid), 1);
        k = (bp < 0) ? int'($urandom_range(5, 0)) : bp;
        repeat (k) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            {in_cout, in_sum} = 5'($urandom);
            tick();
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_data", int'(out_data), e.data);
        end
        in_valid  = 1'b1;
        {in_cout, in_sum} = 5'($urandom);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("hs_idle_busy", int'(busy), 0);
        check("hs_out_valid", int'(out_valid), 0);
        check("held_out_data", int'(out_data), e.data);
        check("held_out_ovf", int'(out_ovf), e.ovf);
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        burst_len = 4'd0;
        in_valid  = 1'b0;
        in_sum    = 4'd0;
        in_cout   = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_ovf", int'(out_ovf), 0);
        repeat (2) tick();
        rst_n = 1'b1;

        // Single sample 16 accepted on the first edge after reset release.
        q = {16};
        run_burst(q, 0, 0, 0);

        // Gapped four-sample burst, five cycles of backpressure.
        q = {5, 10, 30, 1};
        run_burst(q, 3, 0, 5);

        // Sixteen samples of 30 wrap an 8-bit accumulator.
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(30);
        run_burst(q, 1, 0, 1);

        // Abort after two of four samples, then a single-sample burst.
        q = {9, 12, 3, 4};
        run_burst(q, 1, 2, 0);
        q = {7};
        run_burst(q, 0, 0, 0);

        // Asynchronous reset mid-burst takes effect between edges.
        burst_len = 4'd3;
        for (int i = 0; i < 2; i++) begin
            {in_cout, in_sum} = 5'(20 + i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_in_ready", int'(in_ready), 1);
        check("arst_out_data", int'(out_data), 0);
        check("arst_busy", int'(busy), 0);
        tick();
        rst_n = 1'b1;

        // Random bursts with random gaps and backpressure.
        for (int b = 0; b < 25; b++) begin
            int n;
            q.delete();
            n = int'($urandom_range(16, 1));
            for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(31, 0)));
            run_burst(q, 3, 0, -1);
        end

        tick();
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
